counter_arb_ctrl: RTL
=====================

Name: counter_arb_ctrl

Overview:
Controller that shares one CNT_W-bit up-counter between N_REQ requesters. Each requester asks for a count run to a target value. The block grants the counter round-robin, clears and runs it from 0 to the requester's target, then pulses a per-requester done. It sits in front of the 4-bit counter datapath and owns its enable/clear sequencing.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 4, counter width; target and q width
ID_W, 2, width of owner index; must be ≥ clog2(N_REQ)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset; 0 clears all state immediately
req  in  N_REQ  per-requester request level
tgt  in  N_REQ*CNT_W  packed targets; slice i = tgt[i*CNT_W +: CNT_W]; must be stable while req[i]=1
gnt  out  N_REQ  one-hot, current counter owner
done  out  N_REQ  one-cycle pulse to the owner when its run completes
busy  out  1  1 in COUNT or DONE
owner  out  ID_W  index of current or last owner
q  out  CNT_W  live counter value

Behaviour:
- Reset (rst=0, async): state=IDLE, q=0, gnt=0, done=0, busy=0, owner=0, rr pointer=N_REQ-1 (so requester 0 has highest priority first).
- States: IDLE, COUNT, DONE. All outputs are registered.
- IDLE:
  - if any req: pick the first asserted index searching upward from ptr+1 (mod N_REQ).
  - Next edge: state=COUNT, gnt=onehot(winner), owner=winner, ptr=winner, target latched from tgt slice, q=0.
  - If no req: stay in IDLE, q=0.
- COUNT:
  - if q==target_latched, next state is DONE;
  - otherwise q<=q+1.
  - q never wraps, because target ≤ 2^CNT_W-1 and the compare precedes the increment.
  - Target 0: one COUNT cycle, then DONE.
- DONE:
  - gnt=0, done[owner]=1 for exactly one cycle, q holds target, busy=1.
  - Next edge: IDLE, q=0.
- Latency: done pulse asserted T+1 cycles after gnt first asserted (T = target). Minimum request-to-grant latency is 1 cycle. Gap between consecutive grants is DONE + IDLE = 2 cycles.
- Handshake:
  - requester holds req until it sees done.
  - req still high in the IDLE cycle after DONE counts as a new request; round-robin places it last.
- Simultaneous requests: strict round-robin; a continuously requesting master waits at most N_REQ-1 runs.
- New req or tgt changes during COUNT from non-owners are ignored until IDLE.
- Owner's tgt change during COUNT has no effect (target latched).
- Reset mid-run: immediate clear; no done pulse is generated for the aborted run.

Optional Feature:
COUNT_ABORT_EN
- Defined:
  - owner dropping req during COUNT aborts the run: next edge state=IDLE, q=0, gnt=0, no done pulse.
  - ptr still advances past the aborted owner.
- Undefined: req drop during COUNT is ignored; the run completes and done pulses normally.

Decomposition:
- Shared package/include counter_arb_pkg: state encodings (IDLE=2'd0, COUNT=2'd1, DONE=2'd2), default CNT_W/N_REQ, clog2 function.
- One natural sub-module, rr_arbiter: combinational round-robin pick. Inputs req and ptr; outputs one-hot grant and index.
- FSM, counter and target latch stay in the top.

Test Plan:
1. Reset: rst=0 mid-simulation while counting q=3 → same cycle q=0, gnt=0, busy=0, done=0; after release, first grant goes to req0 when req=4'b1111.
2. Single run: req[2]=1, tgt[2]=5 → gnt=4'b0100 next cycle, q counts 0..5, done[2] pulses exactly 6 cycles after gnt rise, q=0 in the following IDLE.
3. Target boundary: tgt=0 → done after 1 COUNT cycle. tgt=15 (CNT_W=4) → q reaches 15, no wrap, done after 16 cycles.
4. Round-robin fairness: req=4'b1111 held continuously, targets=1 → grant order 0,1,2,3,0; 2-cycle gap between runs.
5. Late arrival: req[1] raised during req[3]'s COUNT → ignored until IDLE, then granted. tgt[3] changed mid-run → run still ends at original target.
6. COUNT_ABORT_EN: owner drops req at q=2 → with macro: IDLE next edge, no done. Without macro: run completes and done pulses.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: shared state encodings, default sizes and clog2 helper for counter_arb_ctrl.
package counter_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_e;
    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 4;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/counter_arb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i+1 modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o
);
    logic found;
    int   j;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/counter_arb_ctrl.sv
// counter_arb_ctrl: round-robin owner of a shared up-counter; runs 0..target per grant, pulses done.
// Define COUNT_ABORT_EN to let the owner abort its run by dropping req during COUNT.
module counter_arb_ctrl
    import counter_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] tgt,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [ID_W-1:0]    owner,
    output logic [CNT_W-1:0]   q
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, tgt_q, tgt_d;
    logic [ID_W-1:0]    owner_q, owner_d, ptr_q, ptr_d;
    logic [N_REQ-1:0]   oh_q, oh_d, arb_gnt;
    logic [ID_W-1:0]    arb_idx;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        oh_d    = oh_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    state_d = COUNT;
                    oh_d    = arb_gnt;
                    owner_d = arb_idx;
                    ptr_d   = arb_idx;
                    tgt_d   = tgt[arb_idx*CNT_W +: CNT_W];
                end
            end
            COUNT: begin
`ifdef COUNT_ABORT_EN
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else
`endif
                // compare before increment so the counter never wraps past the target
                if (cnt_q == tgt_q) state_d = DONE;
                else cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= ID_W'(N_REQ - 1);
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            oh_q    <= oh_d;
        end
    end

    assign gnt   = state_q == COUNT ? oh_q : '0;
    assign done  = state_q == DONE ? oh_q : '0;
    assign busy  = state_q != IDLE;
    assign owner = owner_q;
    assign q     = cnt_q;
endmodule
